// File: rtl/counter_pkg.sv
// Shared types and constants for the counter output-side step decoder.
// Imported by the delta classifier and the decoder top.
package counter_pkg;

   typedef enum logic {
      IDLE,
      TRACK
   } dec_state_t;

   typedef enum logic [1:0] {
      HOLD,
      UP,
      DOWN,
      ILLEGAL
   } delta_class_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_delta_classify.sv
// Combinational classifier: sorts the modular difference between two
// successive counter samples into hold/up/down/illegal and detects wrap.
module counter_delta_classify
   import counter_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0] prev,
   input  logic [N-1:0] cur,
   output delta_class_t delta_class,
   output logic         wrap
);

   logic [N-1:0] delta;

   always_comb begin
      delta       = cur - prev;
      delta_class = ILLEGAL;
      wrap        = 1'b0;
      if (delta == '0) begin
         delta_class = HOLD;
      end else if (delta == N'(1)) begin
         delta_class = UP;
      end else if (delta == '1) begin
         delta_class = DOWN;
      end
      // A wrap is only possible on a legal single step across the boundary.
      if (delta_class == UP && prev == '1) begin
         wrap = 1'b1;
      end else if (delta_class == DOWN && prev == '0) begin
         wrap = 1'b1;
      end
   end

endmodule

// File: rtl/counter_step_decoder.sv
// Passive decoder beside the up/down counter: recovers en/up_dn per step,
// flags wrap and illegal jumps, and tracks same-direction run length.
module counter_step_decoder
   import counter_pkg::*;
#(
   parameter int N     = 16,
   parameter int RUN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic [N-1:0]     counter_in,
   input  logic             clr_err,
   output logic             step_valid,
   output logic             step_en,
   output logic             step_up_dn,
   output logic             wrap,
   output logic             err,
   output logic             err_sticky,
   output logic [RUN_W-1:0] run_len
);

   dec_state_t       state, state_nxt;
   logic [N-1:0]     prev, prev_nxt;
   logic             last_dir, last_dir_nxt;
   logic             dir_valid, dir_valid_nxt;

   logic             valid_nxt;
   logic             en_nxt;
   logic             up_dn_nxt;
   logic             wrap_nxt;
   logic             err_nxt;
   logic             sticky_nxt;
   logic [RUN_W-1:0] run_nxt;

   delta_class_t     cls;
   logic             cls_wrap;
   logic             dir;

   counter_delta_classify #(
      .N (N)
   ) u_classify (
      .prev        (prev),
      .cur         (counter_in),
      .delta_class (cls),
      .wrap        (cls_wrap)
   );

   always_comb begin
      state_nxt     = state;
      prev_nxt      = prev;
      last_dir_nxt  = last_dir;
      dir_valid_nxt = dir_valid;
      valid_nxt     = 1'b0;
      en_nxt        = 1'b0;
      up_dn_nxt     = 1'b0;
      wrap_nxt      = 1'b0;
      err_nxt       = 1'b0;
      run_nxt       = run_len;
      dir           = DIR_DN;

      if (sample_en) begin
         prev_nxt = counter_in;
         case (state)
            IDLE: begin
               state_nxt = TRACK;
            end
            TRACK: begin
               valid_nxt = 1'b1;
               case (cls)
                  HOLD: ;
                  UP, DOWN: begin
                     dir       = (cls == UP) ? DIR_UP : DIR_DN;
                     en_nxt    = 1'b1;
                     up_dn_nxt = dir;
                     wrap_nxt  = cls_wrap;
                     if (dir_valid && dir == last_dir) begin
                        run_nxt = (run_len == '1) ? run_len : run_len + RUN_W'(1);
                     end else begin
                        run_nxt = RUN_W'(1);
                     end
                     last_dir_nxt  = dir;
                     dir_valid_nxt = 1'b1;
                  end
                  default: begin
                     // prev is still reloaded so the next sample resyncs.
                     err_nxt       = 1'b1;
                     run_nxt       = '0;
                     dir_valid_nxt = 1'b0;
                  end
               endcase
            end
            default: state_nxt = IDLE;
         endcase
      end

      // A new error outranks a coincident clear.
      if (err_nxt) begin
         sticky_nxt = 1'b1;
      end else if (clr_err) begin
         sticky_nxt = 1'b0;
      end else begin
         sticky_nxt = err_sticky;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         prev       <= '0;
         last_dir   <= DIR_DN;
         dir_valid  <= 1'b0;
         step_valid <= 1'b0;
         step_en    <= 1'b0;
         step_up_dn <= 1'b0;
         wrap       <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         run_len    <= '0;
      end else begin
         state      <= state_nxt;
         prev       <= prev_nxt;
         last_dir   <= last_dir_nxt;
         dir_valid  <= dir_valid_nxt;
         step_valid <= valid_nxt;
         step_en    <= en_nxt;
         step_up_dn <= up_dn_nxt;
         wrap       <= wrap_nxt;
         err        <= err_nxt;
         err_sticky <= sticky_nxt;
         run_len    <= run_nxt;
      end
   end

endmodule

// File: tb/tb_counter_step_decoder.sv
// Bench for counter_step_decoder: directed vector table, saturation sequence,
// and randomized samples checked against an arithmetic reference model.
module tb_counter_step_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_en;
   logic [15:0] counter_in;
   logic        clr_err;
   logic        step_valid;
   logic        step_en;
   logic        step_up_dn;
   logic        wrap;
   logic        err;
   logic        err_sticky;
   logic [7:0]  run_len;

   int errors = 0;
   int checks = 0;

   counter_step_decoder #(
      .N     (16),
      .RUN_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sample_en  (sample_en),
      .counter_in (counter_in),
      .clr_err    (clr_err),
      .step_valid (step_valid),
      .step_en    (step_en),
      .step_up_dn (step_up_dn),
      .wrap       (wrap),
      .err        (err),
      .err_sticky (err_sticky),
      .run_len    (run_len)
   );

   always #5 clk = ~clk;

   // reference model state, expressed in plain integers
   bit m_have_prev;
   int m_prev;
   int m_last_dir;
   bit m_dir_known;
   int m_run;
   int m_sticky;
   int x_valid, x_en, x_up, x_wrap, x_err, x_sticky, x_run;

   typedef struct {
      logic        r;
      logic        s;
      logic [15:0] v;
      logic        c;
      int          valid, en, up, wr, er, st, run;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic s, input logic [15:0] v, input logic c,
                      input int valid, input int en, input int up, input int wr,
                      input int er, input int st, input int run);
      vec_t t;
      t.r = r; t.s = s; t.v = v; t.c = c;
      t.valid = valid; t.en = en; t.up = up; t.wr = wr;
      t.er = er; t.st = st; t.run = run;
      tbl.push_back(t);
   endtask

   task automatic model(input logic r, input logic s, input logic [15:0] v, input logic c);
      int d, dirn;
      x_valid = 0; x_en = 0; x_up = 0; x_wrap = 0; x_err = 0;
      if (r) begin
         m_have_prev = 0; m_dir_known = 0; m_run = 0; m_sticky = 0;
      end else begin
         if (s) begin
            if (!m_have_prev) begin
               m_have_prev = 1;
            end else begin
               x_valid = 1;
               d = (int'(v) - m_prev + 65536) % 65536;
               if (d == 1 || d == 65535) begin
                  dirn   = (d == 1) ? 1 : 0;
                  x_en   = 1;
                  x_up   = dirn;
                  x_wrap = (d == 1) ? (v == 16'h0000) : (v == 16'hFFFF);
                  if (m_dir_known && m_last_dir == dirn)
                     m_run = (m_run + 1 > 255) ? 255 : m_run + 1;
                  else
                     m_run = 1;
                  m_last_dir  = dirn;
                  m_dir_known = 1;
               end else if (d != 0) begin
                  x_err       = 1;
                  m_run       = 0;
                  m_dir_known = 0;
               end
            end
            m_prev = int'(v);
         end
         if (x_err) m_sticky = 1;
         else if (c) m_sticky = 0;
      end
      x_sticky = m_sticky;
      x_run    = m_run;
   endtask

   task automatic step(input logic r, input logic s, input logic [15:0] v, input logic c);
      rst = r; sample_en = s; counter_in = v; clr_err = c;
      model(r, s, v, c);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int valid, input int en, input int up,
                            input int wr, input int er, input int st, input int run);
      check({tag, ".step_valid"}, int'(step_valid), valid);
      check({tag, ".step_en"},    int'(step_en),    en);
      check({tag, ".step_up_dn"}, int'(step_up_dn), up);
      check({tag, ".wrap"},       int'(wrap),       wr);
      check({tag, ".err"},        int'(err),        er);
      check({tag, ".err_sticky"}, int'(err_sticky), st);
      check({tag, ".run_len"},    int'(run_len),    run);
   endtask

   initial begin
      logic [15:0] v;
      logic        r, s, c;
      int          kind;

      rst = 1'b1; sample_en = 1'b0; counter_in = '0; clr_err = 1'b0;

      //   r  s  value     c  vld en up wr er st run
      add(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 16'h0005, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 16'h0006, 0, 1, 1, 1, 0, 0, 0, 1);
      add(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 16'hFFFD, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 16'hFFFE, 0, 1, 1, 1, 0, 0, 0, 1);
      add(0, 1, 16'hFFFF, 0, 1, 1, 1, 0, 0, 0, 2);
      add(0, 1, 16'h0000, 0, 1, 1, 1, 1, 0, 0, 3);
      add(0, 0, 16'h7777, 0, 0, 0, 0, 0, 0, 0, 3);
      add(0, 1, 16'hFFFF, 0, 1, 1, 0, 1, 0, 0, 1);
      add(0, 1, 16'hFFFE, 0, 1, 1, 0, 0, 0, 0, 2);
      add(0, 1, 16'hFFFE, 0, 1, 0, 0, 0, 0, 0, 2);
      add(0, 1, 16'hFFFD, 0, 1, 1, 0, 0, 0, 0, 3);
      add(0, 1, 16'h0010, 0, 1, 0, 0, 0, 1, 1, 0);
      add(0, 1, 16'h0013, 0, 1, 0, 0, 0, 1, 1, 0);
      add(0, 1, 16'h0014, 0, 1, 1, 1, 0, 0, 1, 1);
      add(0, 1, 16'h0015, 1, 1, 1, 1, 0, 0, 0, 2);
      add(0, 1, 16'h0016, 0, 1, 1, 1, 0, 0, 0, 3);
      add(0, 1, 16'h0030, 1, 1, 0, 0, 0, 1, 1, 0);
      add(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 16'h0031, 0, 1, 1, 1, 0, 0, 0, 1);
      add(0, 1, 16'h0032, 0, 1, 1, 1, 0, 0, 0, 2);
      add(0, 1, 16'h9999, 0, 1, 0, 0, 0, 1, 1, 0);
      add(1, 1, 16'h9999, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 16'h1233, 0, 1, 1, 0, 0, 0, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].c);
         check_all($sformatf("vec%0d", i), tbl[i].valid, tbl[i].en, tbl[i].up,
                   tbl[i].wr, tbl[i].er, tbl[i].st, tbl[i].run);
      end

      // 300-step ascending run saturates run_len, then hold and reverse
      step(1, 0, 16'h0000, 0);
      step(0, 1, 16'h0100, 0);
      for (int i = 1; i <= 300; i++) begin
         v = 16'h0100 + 16'(i);
         step(0, 1, v, 0);
         check($sformatf("sat%0d.run_len", i), int'(run_len), (i < 255) ? i : 255);
      end
      step(0, 1, 16'h022C, 0);
      check_all("sat_hold", 1, 0, 0, 0, 0, 0, 255);
      step(0, 1, 16'h022B, 0);
      check_all("sat_down", 1, 1, 0, 0, 0, 0, 1);

      // randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         r    = ($urandom_range(0, 99) == 0);
         s    = ($urandom_range(0, 4) != 0);
         c    = ($urandom_range(0, 9) == 0);
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1, 2: v = 16'(m_prev + 1);
            3, 4, 5: v = 16'(m_prev - 1);
            6:       v = 16'(m_prev);
            7:       v = 16'($urandom);
            8:       v = 16'hFFFF;
            default: v = 16'h0000;
         endcase
         step(r, s, v, c);
         check_all($sformatf("rnd%0d", i), x_valid, x_en, x_up, x_wrap, x_err, x_sticky, x_run);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
